// File: rtl/boid_pixel_writer.sv
// boid_pixel_writer
// Turns per-boid screen positions into framebuffer writes for a 640x480
// palette-index framebuffer: erase the old pixel, draw the new one, and
// clear the whole frame after reset or on request.
// Optional build macro: BOID_SIZE_2X_EN (2x2-pixel boids, edge pixels skipped).
module boid_pixel_writer #(
    parameter int NUM_BOIDS    = 8,
    parameter int VIDEO_WIDTH  = 640,
    parameter int VIDEO_HEIGHT = 480,
    parameter int ADDR_WIDTH   = 20,
    parameter int COLOR_WIDTH  = 8,
    parameter logic [COLOR_WIDTH-1:0] BOID_COLOR = 8'hFF,
    parameter logic [COLOR_WIDTH-1:0] BG_COLOR   = 8'h00,
    localparam int ID_WIDTH = $clog2(NUM_BOIDS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pos_valid,
    output logic                   pos_ready,
    input  logic [ID_WIDTH-1:0]    boid_id,
    input  logic [9:0]             x_loc,
    input  logic [8:0]             y_loc,
    input  logic                   clear_req,
    output logic                   clear_done,
    output logic                   fb_we,
    output logic [ADDR_WIDTH-1:0]  fb_addr,
    output logic [COLOR_WIDTH-1:0] fb_data
);

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ERASE = 2'd2;
    localparam logic [1:0] ST_DRAW  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] CLEAR_LAST = ADDR_WIDTH'(VIDEO_WIDTH * VIDEO_HEIGHT - 1);

    // Linear address y*640 + x built from two shifts and adds.
    function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [9:0] x, input logic [8:0] y);
        logic [ADDR_WIDTH-1:0] ye;
        logic [ADDR_WIDTH-1:0] xe;
        ye = ADDR_WIDTH'(y);
        xe = ADDR_WIDTH'(x);
        return (ye << 9) + (ye << 7) + xe;
    endfunction

    // Address of sub-pixel idx: bit0 adds one to x, bit1 adds one to y.
    function automatic logic [ADDR_WIDTH-1:0] sub_addr(input logic [9:0] x, input logic [8:0] y,
                                                       input logic [1:0] idx);
        return pix_addr(x + {9'd0, idx[0]}, y + {8'd0, idx[1]});
    endfunction

    // Set of on-screen pixels a boid at (x,y) covers; empty when (x,y) is off-screen.
    function automatic logic [3:0] pix_mask(input logic [9:0] x, input logic [8:0] y);
        logic [3:0] m;
        m = 4'b0000;
        if ((int'(x) < VIDEO_WIDTH) && (int'(y) < VIDEO_HEIGHT)) begin
`ifdef BOID_SIZE_2X_EN
            logic xr;
            logic yr;
            xr = ((int'(x) + 1) < VIDEO_WIDTH);
            yr = ((int'(y) + 1) < VIDEO_HEIGHT);
            m  = {xr & yr, yr, xr, 1'b1};
`else
            m = 4'b0001;
`endif
        end else begin
            m = 4'b0000;
        end
        return m;
    endfunction

    // Lowest pending sub-pixel, giving the (x,y),(x+1,y),(x,y+1),(x+1,y+1) order.
    function automatic logic [1:0] first_idx(input logic [3:0] m);
        logic [1:0] r;
        if (m[0]) begin
            r = 2'd0;
        end else if (m[1]) begin
            r = 2'd1;
        end else if (m[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

    logic [1:0]             state_r, state_s;
    logic [ADDR_WIDTH-1:0]  clr_cnt_r, clr_cnt_s;
    logic                   fb_we_r, fb_we_s;
    logic [ADDR_WIDTH-1:0]  fb_addr_r, fb_addr_s;
    logic [COLOR_WIDTH-1:0] fb_data_r, fb_data_s;
    logic                   pos_ready_r, pos_ready_s;
    logic                   clear_done_r, clear_done_s;
    logic [ID_WIDTH-1:0]    cur_id_r, cur_id_s;
    logic [9:0]             cur_x_r, cur_x_s;
    logic [8:0]             cur_y_r, cur_y_s;
    logic [9:0]             old_x_r, old_x_s;
    logic [8:0]             old_y_r, old_y_s;
    logic [3:0]             erase_mask_r, erase_mask_s;
    logic [3:0]             draw_mask_r, draw_mask_s;
    logic [3:0]             mask_s;
    logic [1:0]             idx_s;
    logic                   tbl_we_s;
    logic                   tbl_vld_in_s;
    logic                   tbl_clr_s;

    logic [9:0]             tbl_x_r [NUM_BOIDS];
    logic [8:0]             tbl_y_r [NUM_BOIDS];
    logic [NUM_BOIDS-1:0]   tbl_vld_r;

    assign fb_we      = fb_we_r;
    assign fb_addr    = fb_addr_r;
    assign fb_data    = fb_data_r;
    assign pos_ready  = pos_ready_r;
    assign clear_done = clear_done_r;

    // Next-state and next-output logic; every write is issued one edge ahead so outputs stay registered.
    always_comb begin
        state_s      = state_r;
        clr_cnt_s    = clr_cnt_r;
        fb_we_s      = 1'b0;
        fb_addr_s    = fb_addr_r;
        fb_data_s    = fb_data_r;
        pos_ready_s  = pos_ready_r;
        clear_done_s = clear_done_r;
        cur_id_s     = cur_id_r;
        cur_x_s      = cur_x_r;
        cur_y_s      = cur_y_r;
        old_x_s      = old_x_r;
        old_y_s      = old_y_r;
        erase_mask_s = erase_mask_r;
        draw_mask_s  = draw_mask_r;
        mask_s       = 4'b0000;
        idx_s        = 2'd0;
        tbl_we_s     = 1'b0;
        tbl_vld_in_s = 1'b0;
        tbl_clr_s    = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                fb_we_s   = 1'b1;
                fb_addr_s = clr_cnt_r;
                fb_data_s = BG_COLOR;
                if (clr_cnt_r == CLEAR_LAST) begin
                    clr_cnt_s    = {ADDR_WIDTH{1'b0}};
                    state_s      = ST_IDLE;
                    clear_done_s = 1'b1;
                    pos_ready_s  = 1'b1;
                end else begin
                    clr_cnt_s = clr_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_s      = ST_CLEAR;
                    clr_cnt_s    = {ADDR_WIDTH{1'b0}};
                    clear_done_s = 1'b0;
                    pos_ready_s  = 1'b0;
                    tbl_clr_s    = 1'b1;
                end else if (pos_valid && pos_ready_r) begin
                    pos_ready_s = 1'b0;
                    cur_id_s    = boid_id;
                    cur_x_s     = x_loc;
                    cur_y_s     = y_loc;
                    old_x_s     = tbl_x_r[boid_id];
                    old_y_s     = tbl_y_r[boid_id];
                    if (tbl_vld_r[boid_id]) begin
                        mask_s = pix_mask(tbl_x_r[boid_id], tbl_y_r[boid_id]);
                    end else begin
                        mask_s = 4'b0000;
                    end
                    idx_s = first_idx(mask_s);
                    if (mask_s != 4'b0000) begin
                        fb_we_s      = 1'b1;
                        fb_addr_s    = sub_addr(tbl_x_r[boid_id], tbl_y_r[boid_id], idx_s);
                        fb_data_s    = BG_COLOR;
                        erase_mask_s = mask_s & ~(4'b0001 << idx_s);
                    end else begin
                        erase_mask_s = 4'b0000;
                    end
                    state_s = ST_ERASE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ERASE: begin
                if (erase_mask_r != 4'b0000) begin
                    idx_s        = first_idx(erase_mask_r);
                    fb_we_s      = 1'b1;
                    fb_addr_s    = sub_addr(old_x_r, old_y_r, idx_s);
                    fb_data_s    = BG_COLOR;
                    erase_mask_s = erase_mask_r & ~(4'b0001 << idx_s);
                end else begin
                    mask_s       = pix_mask(cur_x_r, cur_y_r);
                    idx_s        = first_idx(mask_s);
                    tbl_we_s     = 1'b1;
                    tbl_vld_in_s = (mask_s != 4'b0000);
                    if (mask_s != 4'b0000) begin
                        fb_we_s     = 1'b1;
                        fb_addr_s   = sub_addr(cur_x_r, cur_y_r, idx_s);
                        fb_data_s   = BOID_COLOR;
                        draw_mask_s = mask_s & ~(4'b0001 << idx_s);
                    end else begin
                        draw_mask_s = 4'b0000;
                    end
                    state_s = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (draw_mask_r != 4'b0000) begin
                    idx_s       = first_idx(draw_mask_r);
                    fb_we_s     = 1'b1;
                    fb_addr_s   = sub_addr(cur_x_r, cur_y_r, idx_s);
                    fb_data_s   = BOID_COLOR;
                    draw_mask_s = draw_mask_r & ~(4'b0001 << idx_s);
                end else begin
                    state_s     = ST_IDLE;
                    pos_ready_s = 1'b1;
                end
            end
            default: begin
                state_s      = ST_CLEAR;
                clr_cnt_s    = {ADDR_WIDTH{1'b0}};
                pos_ready_s  = 1'b0;
                clear_done_s = 1'b0;
                tbl_clr_s    = 1'b1;
            end
        endcase
    end

    // Control and output registers; reset restarts the frame clear at address 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_CLEAR;
            clr_cnt_r    <= {ADDR_WIDTH{1'b0}};
            fb_we_r      <= 1'b0;
            fb_addr_r    <= {ADDR_WIDTH{1'b0}};
            fb_data_r    <= {COLOR_WIDTH{1'b0}};
            pos_ready_r  <= 1'b0;
            clear_done_r <= 1'b0;
            cur_id_r     <= {ID_WIDTH{1'b0}};
            cur_x_r      <= 10'd0;
            cur_y_r      <= 9'd0;
            old_x_r      <= 10'd0;
            old_y_r      <= 9'd0;
            erase_mask_r <= 4'b0000;
            draw_mask_r  <= 4'b0000;
        end else begin
            state_r      <= state_s;
            clr_cnt_r    <= clr_cnt_s;
            fb_we_r      <= fb_we_s;
            fb_addr_r    <= fb_addr_s;
            fb_data_r    <= fb_data_s;
            pos_ready_r  <= pos_ready_s;
            clear_done_r <= clear_done_s;
            cur_id_r     <= cur_id_s;
            cur_x_r      <= cur_x_s;
            cur_y_r      <= cur_y_s;
            old_x_r      <= old_x_s;
            old_y_r      <= old_y_s;
            erase_mask_r <= erase_mask_s;
            draw_mask_r  <= draw_mask_s;
        end
    end

    // Last-drawn position table; an entry is valid only while its boid is on-screen.
    always_ff @(posedge clock) begin
        if (reset) begin
            tbl_vld_r <= {NUM_BOIDS{1'b0}};
            for (int i = 0; i < NUM_BOIDS; i++) begin
                tbl_x_r[i] <= 10'd0;
                tbl_y_r[i] <= 9'd0;
            end
        end else if (tbl_clr_s) begin
            tbl_vld_r <= {NUM_BOIDS{1'b0}};
        end else if (tbl_we_s) begin
            tbl_vld_r[cur_id_r] <= tbl_vld_in_s;
            tbl_x_r[cur_id_r]   <= cur_x_r;
            tbl_y_r[cur_id_r]   <= cur_y_r;
        end else begin
            tbl_vld_r <= tbl_vld_r;
        end
    end

endmodule

// File: tb/tb_boid_pixel_writer.sv
// Directed bench for boid_pixel_writer (single-pixel build). The frame height
// is reduced to 30 lines so each full clear is 19200 cycles; address
// arithmetic is independent of the height, so expected addresses are y*640+x.
module tb_boid_pixel_writer;

    localparam int W = 640;
    localparam int H = 30;
    localparam int N = W * H;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pos_valid = 1'b0;
    logic        clear_req = 1'b0;
    logic [2:0]  boid_id = 3'd0;
    logic [9:0]  x_loc = 10'd0;
    logic [8:0]  y_loc = 9'd0;
    logic        pos_ready;
    logic        clear_done;
    logic        fb_we;
    logic [19:0] fb_addr;
    logic [7:0]  fb_data;

    int checks = 0;
    int errors = 0;

    logic        we1, we2, we3, rdy1, rdy3;
    logic [19:0] a1, a2, a3;
    logic [7:0]  d1, d2;

    boid_pixel_writer #(
        .NUM_BOIDS(8), .VIDEO_WIDTH(W), .VIDEO_HEIGHT(H),
        .ADDR_WIDTH(20), .COLOR_WIDTH(8), .BOID_COLOR(8'hFF), .BG_COLOR(8'h00)
    ) dut (
        .clock(clock), .reset(reset), .pos_valid(pos_valid), .pos_ready(pos_ready),
        .boid_id(boid_id), .x_loc(x_loc), .y_loc(y_loc), .clear_req(clear_req),
        .clear_done(clear_done), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
    );

    always #10 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one position at the current negedge and capture cycles T+1..T+3.
    task automatic xact(input logic [2:0] id, input logic [9:0] x, input logic [8:0] y,
                        input logic busy_clr);
        pos_valid = 1'b1; boid_id = id; x_loc = x; y_loc = y;
        @(negedge clock);
        we1 = fb_we; a1 = fb_addr; d1 = fb_data; rdy1 = pos_ready;
        pos_valid = 1'b0; clear_req = busy_clr;
        @(negedge clock);
        we2 = fb_we; a2 = fb_addr; d2 = fb_data;
        @(negedge clock);
        we3 = fb_we; a3 = fb_addr; rdy3 = pos_ready;
        clear_req = 1'b0;
    endtask

    // Watch a whole clear: N background writes at ascending addresses, then idle.
    task automatic clear_watch(input string tag);
        int cnt = 0;
        int bad = 0;
        bit done = 1'b0;
        for (int i = 0; i < N + 50 && !done; i++) begin
            @(negedge clock);
            if (fb_we === 1'b1) begin
                if (fb_addr !== 20'(cnt) || fb_data !== 8'h00) bad++;
                cnt++;
            end
            if (clear_done === 1'b1) done = 1'b1;
        end
        chk({tag, "_writes"}, 32'(cnt), 32'(N));
        chk({tag, "_order"}, 32'(bad), 32'd0);
        chk({tag, "_done"}, 32'(clear_done), 32'd1);
        chk({tag, "_ready"}, 32'(pos_ready), 32'd1);
        @(negedge clock);
        chk({tag, "_quiet"}, 32'(fb_we), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_data", 32'(fb_data), 32'd0);
        chk("rst_ready", 32'(pos_ready), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        reset = 1'b0;
        clear_watch("init");

        // Boid 0 at (100,10) into an empty table: draw only at 6500
        xact(3'd0, 10'd100, 9'd10, 1'b0);
        chk("b0a_ready_t1", 32'(rdy1), 32'd0);
        chk("b0a_we_t1", 32'(we1), 32'd0);
        chk("b0a_we_t2", 32'(we2), 32'd1);
        chk("b0a_addr_t2", 32'(a2), 32'd6500);
        chk("b0a_data_t2", 32'(d2), 32'hFF);
        chk("b0a_ready_t3", 32'(rdy3), 32'd1);
        chk("b0a_we_t3", 32'(we3), 32'd0);
        chk("b0a_hold_t3", 32'(a3), 32'd6500);

        // Boid 0 to bottom-right corner (639,29): erase 6500, draw 19199
        xact(3'd0, 10'd639, 9'd29, 1'b0);
        chk("b0b_we_t1", 32'(we1), 32'd1);
        chk("b0b_addr_t1", 32'(a1), 32'd6500);
        chk("b0b_data_t1", 32'(d1), 32'h00);
        chk("b0b_we_t2", 32'(we2), 32'd1);
        chk("b0b_addr_t2", 32'(a2), 32'd19199);
        chk("b0b_data_t2", 32'(d2), 32'hFF);

        // Boid 3 at (5,5), then off-screen (640,10), then back on at (7,7)
        xact(3'd3, 10'd5, 9'd5, 1'b0);
        chk("b3a_we_t1", 32'(we1), 32'd0);
        chk("b3a_addr_t2", 32'(a2), 32'd3205);
        xact(3'd3, 10'd640, 9'd10, 1'b0);
        chk("b3b_we_t1", 32'(we1), 32'd1);
        chk("b3b_addr_t1", 32'(a1), 32'd3205);
        chk("b3b_data_t1", 32'(d1), 32'h00);
        chk("b3b_we_t2", 32'(we2), 32'd0);
        chk("b3b_hold_t2", 32'(a2), 32'd3205);
        xact(3'd3, 10'd7, 9'd7, 1'b0);
        chk("b3c_we_t1", 32'(we1), 32'd0);
        chk("b3c_we_t2", 32'(we2), 32'd1);
        chk("b3c_addr_t2", 32'(a2), 32'd4487);

        // Boid 5 at y = height (off-screen), then at last line
        xact(3'd5, 10'd0, 9'd30, 1'b0);
        chk("b5a_we_t1", 32'(we1), 32'd0);
        chk("b5a_we_t2", 32'(we2), 32'd0);
        xact(3'd5, 10'd0, 9'd29, 1'b0);
        chk("b5b_we_t1", 32'(we1), 32'd0);
        chk("b5b_addr_t2", 32'(a2), 32'd18560);

        // Same-position redraw of boid 0 while clear_req is pulsed mid-transaction
        xact(3'd0, 10'd639, 9'd29, 1'b1);
        chk("same_we_t1", 32'(we1), 32'd1);
        chk("same_addr_t1", 32'(a1), 32'd19199);
        chk("same_data_t1", 32'(d1), 32'h00);
        chk("same_addr_t2", 32'(a2), 32'd19199);
        chk("same_data_t2", 32'(d2), 32'hFF);
        @(negedge clock);
        chk("busyclr_done", 32'(clear_done), 32'd1);
        chk("busyclr_we", 32'(fb_we), 32'd0);
        chk("busyclr_ready", 32'(pos_ready), 32'd1);

        // clear_req together with pos_valid: clear wins
        clear_req = 1'b1; pos_valid = 1'b1; boid_id = 3'd1; x_loc = 10'd1; y_loc = 9'd1;
        @(negedge clock);
        clear_req = 1'b0; pos_valid = 1'b0;
        chk("req_done_low", 32'(clear_done), 32'd0);
        chk("req_ready_low", 32'(pos_ready), 32'd0);
        chk("req_we", 32'(fb_we), 32'd0);
        clear_watch("req");
        xact(3'd0, 10'd20, 9'd1, 1'b0);
        chk("postreq_we_t1", 32'(we1), 32'd0);
        chk("postreq_addr_t2", 32'(a2), 32'd660);
        chk("postreq_data_t2", 32'(d2), 32'hFF);

        // Reset at clear address 1000 restarts the clear from 0
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (fb_we === 1'b1 && fb_addr === 20'd1000) break;
        end
        chk("mid_reach", 32'(fb_addr), 32'd1000);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_we", 32'(fb_we), 32'd0);
        chk("mid_rst_done", 32'(clear_done), 32'd0);
        reset = 1'b0;
        clear_watch("rst");
        xact(3'd0, 10'd20, 9'd1, 1'b0);
        chk("postrst_we_t1", 32'(we1), 32'd0);
        chk("postrst_addr_t2", 32'(a2), 32'd660);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
